// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: opcode and sequencer state encodings shared by the sequencer, ALU and benches.
package cpu_defs_pkg;
    localparam int OPC_W = 3;
    typedef enum logic [OPC_W-1:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_BNE   = 3'b100,
        OP_BRA   = 3'b101,
        OP_HALT  = 3'b110,
        OP_NOP   = 3'b111
    } opcode_t;
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_ADDR,
        S_FETCH_DATA,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;
endpackage

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: microcoded-style control FSM for the accumulator CPU.
// Outputs are Mealy: decoded from state, opcode, z_flag and mem_ready.
module cpu_sequencer
    import cpu_defs_pkg::*;
#(
    parameter int OP_W = 3
) (
    input  logic            clock,
    input  logic            n_reset,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic            z_flag,
    input  logic            mem_ready,
    output logic            ACC_bus,
    output logic            load_ACC,
    output logic            ALU_ACC,
    output logic            ALU_add,
    output logic            ALU_sub,
    output logic            PC_bus,
    output logic            load_PC,
    output logic            INC_PC,
    output logic            load_IR,
    output logic            Addr_bus,
    output logic            load_MAR,
    output logic            CS,
    output logic            R_NW,
    output logic            halted
);
    state_t  state_q, state_d;
    opcode_t opc;

    assign opc = opcode_t'(op[OPC_W-1:0]);

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        ACC_bus  = 1'b0;
        load_ACC = 1'b0;
        ALU_ACC  = 1'b0;
        ALU_add  = 1'b0;
        ALU_sub  = 1'b0;
        PC_bus   = 1'b0;
        load_PC  = 1'b0;
        INC_PC   = 1'b0;
        load_IR  = 1'b0;
        Addr_bus = 1'b0;
        load_MAR = 1'b0;
        CS       = 1'b0;
        R_NW     = 1'b0;
        halted   = 1'b0;
        case (state_q)
            S_IDLE: state_d = start ? S_FETCH_ADDR : S_IDLE;
            S_FETCH_ADDR: begin
                PC_bus   = 1'b1;
                load_MAR = 1'b1;
                INC_PC   = 1'b1;
                load_PC  = 1'b1;
                state_d  = S_FETCH_DATA;
            end
            S_FETCH_DATA: begin
                CS      = 1'b1;
                R_NW    = 1'b1;
                load_IR = mem_ready;
                state_d = mem_ready ? S_DECODE : S_FETCH_DATA;
            end
            S_DECODE: begin
                case (opc)
                    OP_LOAD, OP_STORE, OP_ADD, OP_SUB: begin
                        Addr_bus = 1'b1;
                        load_MAR = 1'b1;
                        state_d  = S_EXEC;
                    end
                    OP_BRA, OP_BNE: begin
                        Addr_bus = (opc == OP_BRA) || !z_flag;
                        load_PC  = (opc == OP_BRA) || !z_flag;
                        state_d  = S_FETCH_ADDR;
                    end
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_FETCH_ADDR;
                endcase
            end
            S_EXEC: begin
                // load_ACC gated by mem_ready so each accumulate fires exactly once
                CS       = 1'b1;
                R_NW     = (opc != OP_STORE);
                ACC_bus  = (opc == OP_STORE);
                ALU_ACC  = (opc == OP_ADD) || (opc == OP_SUB);
                ALU_add  = (opc == OP_ADD);
                ALU_sub  = (opc == OP_SUB);
                load_ACC = mem_ready && (opc != OP_STORE);
                state_d  = mem_ready ? S_FETCH_ADDR : S_EXEC;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: table-driven program trace plus hand-written reset corner cases.
module tb_cpu_sequencer;
    localparam logic [13:0] B_ACC_BUS = 14'h2000, B_LD_ACC = 14'h1000, B_ALU_ACC = 14'h0800,
                            B_ADD = 14'h0400, B_SUB = 14'h0200, B_PC_BUS = 14'h0100,
                            B_LD_PC = 14'h0080, B_INC_PC = 14'h0040, B_LD_IR = 14'h0020,
                            B_ADDR = 14'h0010, B_LD_MAR = 14'h0008, B_CS = 14'h0004,
                            B_RNW = 14'h0002, B_HALT = 14'h0001;
    localparam logic [13:0] FA   = B_PC_BUS | B_LD_MAR | B_INC_PC | B_LD_PC;
    localparam logic [13:0] FDW  = B_CS | B_RNW;
    localparam logic [13:0] FDR  = B_CS | B_RNW | B_LD_IR;
    localparam logic [13:0] DECM = B_ADDR | B_LD_MAR;
    localparam logic [13:0] DECB = B_ADDR | B_LD_PC;
    localparam logic [13:0] LDR  = B_CS | B_RNW | B_LD_ACC;
    localparam logic [13:0] ADW  = B_CS | B_RNW | B_ALU_ACC | B_ADD;
    localparam logic [13:0] SBR  = B_CS | B_RNW | B_ALU_ACC | B_SUB | B_LD_ACC;
    localparam logic [13:0] ST   = B_CS | B_ACC_BUS;

    typedef struct {
        logic        st;
        logic [2:0]  op;
        logic        z;
        logic        mr;
        logic [13:0] exp;
    } vec_t;

    logic clock = 1'b0, n_reset = 1'b0, start = 1'b0, z_flag = 1'b0, mem_ready = 1'b0;
    logic [2:0] op = 3'b000;
    logic ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, PC_bus, load_PC, INC_PC,
          load_IR, Addr_bus, load_MAR, CS, R_NW, halted;
    logic [13:0] outs;
    int errors = 0, checks = 0;
    vec_t v[$];

    always #5 clock = ~clock;

    cpu_sequencer #(.OP_W(3)) dut (
        .clock(clock), .n_reset(n_reset), .start(start), .op(op), .z_flag(z_flag),
        .mem_ready(mem_ready), .ACC_bus(ACC_bus), .load_ACC(load_ACC), .ALU_ACC(ALU_ACC),
        .ALU_add(ALU_add), .ALU_sub(ALU_sub), .PC_bus(PC_bus), .load_PC(load_PC),
        .INC_PC(INC_PC), .load_IR(load_IR), .Addr_bus(Addr_bus), .load_MAR(load_MAR),
        .CS(CS), .R_NW(R_NW), .halted(halted)
    );

    assign outs = {ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, PC_bus, load_PC, INC_PC,
                   load_IR, Addr_bus, load_MAR, CS, R_NW, halted};

    task automatic chk(input string nm, input logic [13:0] exp);
        checks++;
        if (outs !== exp || (ALU_add && ALU_sub) || (load_ACC && ACC_bus)) begin
            errors++;
            $display("FAIL %s: outputs=%014b expected=%014b", nm, outs, exp);
        end
    endtask

    task automatic add(input logic st, input logic [2:0] o, input logic z, input logic mr,
                       input logic [13:0] exp);
        vec_t t;
        t.st = st; t.op = o; t.z = z; t.mr = mr; t.exp = exp;
        v.push_back(t);
    endtask

    initial begin
        add(0, 3'b000, 0, 1, 14'h0);
        add(1, 3'b000, 0, 1, 14'h0);
        add(0, 3'b000, 0, 1, FA);
        add(0, 3'b000, 0, 1, FDR);
        add(0, 3'b000, 0, 1, DECM);
        add(0, 3'b000, 0, 1, LDR);
        add(0, 3'b010, 0, 1, FA);
        add(0, 3'b010, 0, 0, FDW);
        add(0, 3'b010, 0, 1, FDR);
        add(0, 3'b010, 0, 1, DECM);
        add(0, 3'b010, 0, 0, ADW);
        add(0, 3'b010, 0, 0, ADW);
        add(0, 3'b010, 0, 0, ADW);
        add(0, 3'b010, 0, 1, ADW | B_LD_ACC);
        add(0, 3'b100, 0, 1, FA);
        add(0, 3'b100, 0, 1, FDR);
        add(0, 3'b100, 0, 1, DECB);
        add(0, 3'b100, 1, 1, FA);
        add(0, 3'b100, 1, 1, FDR);
        add(0, 3'b100, 1, 1, 14'h0);
        add(0, 3'b101, 1, 1, FA);
        add(0, 3'b101, 1, 1, FDR);
        add(0, 3'b101, 1, 1, DECB);
        add(0, 3'b111, 0, 1, FA);
        add(0, 3'b111, 0, 1, FDR);
        add(0, 3'b111, 0, 1, 14'h0);
        add(1, 3'b001, 0, 1, FA);
        add(1, 3'b001, 0, 1, FDR);
        add(0, 3'b001, 0, 1, DECM);
        add(0, 3'b001, 0, 0, ST);
        add(0, 3'b001, 0, 1, ST);
        add(0, 3'b011, 0, 1, FA);
        add(0, 3'b011, 0, 1, FDR);
        add(0, 3'b011, 0, 1, DECM);
        add(0, 3'b011, 0, 1, SBR);
        add(0, 3'b110, 0, 1, FA);
        add(0, 3'b110, 0, 1, FDR);
        add(0, 3'b110, 0, 1, 14'h0);
        for (int i = 0; i < 10; i++) add(i[0], 3'b110, 0, 1, B_HALT);

        #1 chk("reset", 14'h0);
        @(negedge clock) n_reset = 1'b1;
        foreach (v[i]) begin
            start = v[i].st; op = v[i].op; z_flag = v[i].z; mem_ready = v[i].mr;
            #1 chk($sformatf("vec%0d", i), v[i].exp);
            @(negedge clock);
        end

        start = 1'b0;
        n_reset = 1'b0;
        #1 chk("halt_reset_async", 14'h0);
        @(negedge clock) n_reset = 1'b1;
        #1 chk("idle_after_halt", 14'h0);
        @(negedge clock) chk("idle_stays", 14'h0);
        start = 1'b1;
        @(negedge clock) start = 1'b0;
        #1 chk("restart_fa", FA);
        @(negedge clock) mem_ready = 1'b0;
        #1 chk("fd_wait", FDW);
        #2 n_reset = 1'b0;
        #1 chk("fd_reset_async", 14'h0);
        @(negedge clock) chk("fd_reset_held", 14'h0);
        start = 1'b1;
        n_reset = 1'b1;
        #1 chk("release_idle", 14'h0);
        @(negedge clock) start = 1'b0;
        #1 chk("first_edge_fa", FA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL have parameter OP_W, default 3: opcode width.
REQ-002 The block SHALL have port clock, input, 1, system clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port n_reset, input, 1, reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1, begins execution from idle.
REQ-005 The block SHALL have port op, input, OP_W, opcode field of the instruction register.
REQ-006 The block SHALL have port z_flag, input, 1, accumulator-zero flag from the ALU.
REQ-007 The block SHALL have port mem_ready, input, 1, memory completes the current access this cycle.
REQ-008 The block SHALL have ports ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, each output, 1, ALU controls.
REQ-009 The block SHALL have ports PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR, each output, 1, PC, IR and MAR controls.
REQ-010 The block SHALL have ports CS and R_NW, each output, 1: memory select, and read(1)/write(0).
REQ-011 The block SHALL have port halted, output, 1, high while in HALT.

Function
REQ-012 Opcodes SHALL be: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 BNE, 101 BRA, 110 HALT, 111 NOP.
REQ-013 The FSM SHALL have states IDLE, FETCH_ADDR, FETCH_DATA, DECODE, EXEC, HALT.
REQ-014 Outputs SHALL be combinational from state, op, z_flag and mem_ready; all outputs not listed for a state SHALL be 0, R_NW SHALL be 0 unless stated.
REQ-015 IDLE: no outputs asserted; start=1 -> FETCH_ADDR, else stay.
REQ-016 FETCH_ADDR: PC_bus, load_MAR, INC_PC, load_PC asserted; -> FETCH_DATA unconditionally.
REQ-017 FETCH_DATA: CS, R_NW held; load_IR asserted only in the cycle mem_ready=1; mem_ready=1 -> DECODE, else stay.
REQ-018 DECODE with LOAD/STORE/ADD/SUB: Addr_bus, load_MAR; -> EXEC.
REQ-019 DECODE with BRA, or with BNE and z_flag=0: Addr_bus, load_PC; -> FETCH_ADDR.
REQ-020 DECODE with BNE and z_flag=1, or NOP: nothing asserted; -> FETCH_ADDR.
REQ-021 DECODE with HALT: -> HALT.
REQ-022 EXEC with LOAD: CS, R_NW held; load_ACC (ALU_ACC=0) only in the cycle mem_ready=1.
REQ-023 EXEC with ADD or SUB: CS, R_NW, ALU_ACC held; ALU_add or ALU_sub held respectively; load_ACC only in the cycle mem_ready=1.
REQ-024 EXEC with STORE: CS, ACC_bus held, R_NW=0 throughout.
REQ-025 EXEC: mem_ready=1 -> FETCH_ADDR, else stay with the same outputs, so each accumulate fires exactly once per instruction.
REQ-026 HALT: halted=1, no other outputs asserted; start SHALL be ignored; exit only by reset.
REQ-027 With mem_ready tied 1: memory instructions SHALL take 4 cycles; branch, NOP and not-taken BNE SHALL take 3 cycles.
REQ-028 start asserted outside IDLE SHALL have no effect.
REQ-029 ALU_add and ALU_sub SHALL never be asserted together, and load_ACC and ACC_bus SHALL never be asserted together.

Reset
REQ-030 n_reset=0 SHALL force IDLE asynchronously from any state, including mid-wait in FETCH_DATA or EXEC.
REQ-031 All outputs, including halted, SHALL be 0 while in reset and in IDLE.
REQ-032 The FSM SHALL leave IDLE no earlier than the first rising edge after n_reset deasserts with start=1.

Structure
REQ-033 The opcode enum (OP_W bits) and state enum SHALL live in a shared package cpu_defs_pkg, for use by this block, the ALU and benches.
REQ-034 The block SHALL be a single module with a state register and combinational next-state/output logic; no sub-module is required.

Verification
REQ-035 Reset, start=1, op=LOAD, mem_ready=1 -> state sequence FETCH_ADDR, FETCH_DATA, DECODE, EXEC; exactly one load_ACC pulse, with ALU_ACC=0.
REQ-036 op=ADD, mem_ready low for 3 EXEC cycles then high -> CS, ALU_ACC and ALU_add held 4 cycles; load_ACC high in the 4th only; then FETCH_ADDR.
REQ-037 op=BNE: with z_flag=0 -> Addr_bus and load_PC in DECODE; with z_flag=1 -> neither asserted; both return to FETCH_ADDR.
REQ-038 op=STORE -> R_NW=0 and ACC_bus=1 throughout EXEC, with load_ACC never asserted.
REQ-039 op=HALT -> halted=1 persists over 10 cycles with start pulsed; n_reset pulse -> IDLE, halted=0.
REQ-040 n_reset asserted mid-FETCH_DATA wait -> all outputs 0 immediately, before the next clock edge; state IDLE.
